// File: rtl/dma_desc_dispatch_if.sv
// -----------------------------------------------------------------------------
// dma_desc_dispatch_if
// Bundles the dispatcher's two outbound channels:
//   * transfer command to the data mover (valid/ready handshake, src/dst/len/id)
//     plus the mover's single-cycle completion report (done/bytes/error)
//   * AVMM write master used for descriptor writeback (write/addr/wrdata,
//     stalled by waitrequest)
// Signal suffixes are from the dispatcher's point of view: master = dispatcher,
// slave = data mover / descriptor memory side.
// -----------------------------------------------------------------------------
interface dma_desc_dispatch_if;
    // Transfer command channel
    logic        dma_xfer_cmd_valid_o;
    logic        dma_xfer_cmd_ready_i;
    logic [31:0] dma_xfer_src_addr_o;
    logic [31:0] dma_xfer_dst_addr_o;
    logic [31:0] dma_xfer_len_o;
    logic [7:0]  dma_xfer_id_o;
    // Completion report
    logic        dma_xfer_done_i;
    logic [31:0] dma_xfer_bytes_i;
    logic [7:0]  dma_xfer_error_i;
    // Descriptor writeback (AVMM write master)
    logic        dma_desc_wb_write_o;
    logic [31:0] dma_desc_wb_addr_o;
    logic [31:0] dma_desc_wb_wrdata_o;
    logic        dma_desc_wb_waitrequest_i;

    modport master (
        output dma_xfer_cmd_valid_o,
        input  dma_xfer_cmd_ready_i,
        output dma_xfer_src_addr_o,
        output dma_xfer_dst_addr_o,
        output dma_xfer_len_o,
        output dma_xfer_id_o,
        input  dma_xfer_done_i,
        input  dma_xfer_bytes_i,
        input  dma_xfer_error_i,
        output dma_desc_wb_write_o,
        output dma_desc_wb_addr_o,
        output dma_desc_wb_wrdata_o,
        input  dma_desc_wb_waitrequest_i
    );

    modport slave (
        input  dma_xfer_cmd_valid_o,
        output dma_xfer_cmd_ready_i,
        input  dma_xfer_src_addr_o,
        input  dma_xfer_dst_addr_o,
        input  dma_xfer_len_o,
        input  dma_xfer_id_o,
        output dma_xfer_done_i,
        output dma_xfer_bytes_i,
        output dma_xfer_error_i,
        input  dma_desc_wb_write_o,
        input  dma_desc_wb_addr_o,
        input  dma_desc_wb_wrdata_o,
        output dma_desc_wb_waitrequest_i
    );
endinterface

// File: rtl/dma_desc_dispatch.sv
// -----------------------------------------------------------------------------
// dma_desc_dispatch
// Pops 265-bit descriptor entries from a show-ahead FIFO, issues one transfer
// command per descriptor, waits for completion and writes the actual byte count
// (word6) and status (word7, owned-by-hw cleared, error in low byte) back to
// descriptor memory. The descriptor's own address is not in the FIFO entry, so
// it is tracked here by following next pointers (word4) and returning to the
// chain head on an end-of-chain entry or whenever run is low.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   csr_control_i          bit5 run, bit4 irq enable
//   csr_first_pointer_i    chain head address
//   dma_desc_fifo_*        show-ahead FIFO read side (empty/rddata/rd)
//   xfer                   command/completion + AVMM writeback (master modport)
//   dma_dispatch_busy_o    high whenever not idle
//   dma_desc_irq_o         one-cycle pulse after each status writeback (irq en)
//   dma_chain_done_o       one-cycle pulse while decoding an end-of-chain entry
// -----------------------------------------------------------------------------
module dma_desc_dispatch (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         csr_control_i,
    input  logic [31:0]         csr_first_pointer_i,
    input  logic                dma_desc_fifo_empty_i,
    input  logic [264:0]        dma_desc_fifo_rddata_i,
    output logic                dma_desc_fifo_rd_o,
    dma_desc_dispatch_if.master xfer,
    output logic                dma_dispatch_busy_o,
    output logic                dma_desc_irq_o,
    output logic                dma_chain_done_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WB_LEN    = 3'd4,
        S_WB_STAT   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [264:0]  entry_q, entry_d;
    logic [31:0]   bytes_q, bytes_d;
    logic [7:0]    err_q, err_d;
    logic [31:0]   cur_addr_q, cur_addr_d;
    logic          irq_q, irq_d;

    // Field views of the latched entry
    logic          ent_eoc;
    logic [7:0]    ent_id;
    logic [31:0]   ent_src, ent_dst, ent_next, ent_len, ent_ctrl;

    assign ent_eoc  = entry_q[264];
    assign ent_id   = entry_q[263:256];
    assign ent_src  = entry_q[31:0];
    assign ent_dst  = entry_q[95:64];
    assign ent_next = entry_q[159:128];
    assign ent_len  = entry_q[223:192];
    assign ent_ctrl = entry_q[255:224];

    logic run;
    assign run = csr_control_i[5];

    // Entry words 1/3/5, status bit31 and status low byte are overwritten or
    // irrelevant; the unused CSR bits likewise.
    logic unused_bits;
    assign unused_bits = ^{entry_q[63:32], entry_q[127:96], entry_q[191:160],
                           ent_ctrl[31], ent_ctrl[7:0],
                           csr_control_i[31:6], csr_control_i[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            entry_q    <= '0;
            bytes_q    <= '0;
            err_q      <= '0;
            cur_addr_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            bytes_q    <= bytes_d;
            err_q      <= err_d;
            cur_addr_q <= cur_addr_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        bytes_d    = bytes_q;
        err_d      = err_q;
        cur_addr_d = cur_addr_q;
        irq_d      = 1'b0;

        dma_desc_fifo_rd_o         = 1'b0;
        xfer.dma_xfer_cmd_valid_o  = 1'b0;
        xfer.dma_desc_wb_write_o   = 1'b0;
        xfer.dma_desc_wb_addr_o    = '0;
        xfer.dma_desc_wb_wrdata_o  = '0;
        dma_chain_done_o           = 1'b0;

        // Strobes are held low while reset is asserted so nothing is popped,
        // issued or written before the state register has been cleared.
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (!dma_desc_fifo_empty_i) begin
                        dma_desc_fifo_rd_o = 1'b1;
                        entry_d            = dma_desc_fifo_rddata_i;
                        state_d            = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (ent_eoc) begin
                        dma_chain_done_o = 1'b1;
                        cur_addr_d       = csr_first_pointer_i;
                        state_d          = S_IDLE;
                    end else if (ent_len == '0) begin
                        // Nothing to move: report zero bytes, no error
                        bytes_d = '0;
                        err_d   = '0;
                        state_d = S_WB_LEN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    xfer.dma_xfer_cmd_valid_o = 1'b1;
                    if (xfer.dma_xfer_cmd_ready_i) begin
                        state_d = S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (xfer.dma_xfer_done_i) begin
                        bytes_d = xfer.dma_xfer_bytes_i;
                        err_d   = xfer.dma_xfer_error_i;
                        state_d = S_WB_LEN;
                    end
                end
                S_WB_LEN: begin
                    xfer.dma_desc_wb_write_o  = 1'b1;
                    xfer.dma_desc_wb_addr_o   = cur_addr_q + 32'h18;
                    xfer.dma_desc_wb_wrdata_o = bytes_q;
                    if (!xfer.dma_desc_wb_waitrequest_i) begin
                        state_d = S_WB_STAT;
                    end
                end
                S_WB_STAT: begin
                    xfer.dma_desc_wb_write_o  = 1'b1;
                    xfer.dma_desc_wb_addr_o   = cur_addr_q + 32'h1C;
                    xfer.dma_desc_wb_wrdata_o = {1'b0, ent_ctrl[30:8], err_q};
                    if (!xfer.dma_desc_wb_waitrequest_i) begin
                        cur_addr_d = ent_next;
                        irq_d      = csr_control_i[4];
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // With run low the tracker always points at the chain head; this wins
        // over the next-pointer follow above.
        if (!run) begin
            cur_addr_d = csr_first_pointer_i;
        end
    end

    assign xfer.dma_xfer_src_addr_o = ent_src;
    assign xfer.dma_xfer_dst_addr_o = ent_dst;
    assign xfer.dma_xfer_len_o      = ent_len;
    assign xfer.dma_xfer_id_o       = ent_id;

    assign dma_dispatch_busy_o = (state_q != S_IDLE);
    assign dma_desc_irq_o      = irq_q;

endmodule
